// File: rtl/immediate_pack.sv
// immediate_pack: streaming RISC-V instruction encoder.
// Packs opcode/register/funct fields and a decoder-convention immediate into a
// 32-bit word, queues it in a 2-entry buffer (output reg + skid reg) and tags
// it with an auto-incrementing instruction-memory byte address.
// Optional build macro: IMM_RANGE_CHECK_EN flags immediates that do not fit
// their field (the truncated field is still emitted).
module immediate_pack #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } word_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));
    localparam word_t       RST_WORD  = '{instr: 32'h0, addr: BASE_ADDR, err: 1'b0};

    state_t      state, state_nxt;
    word_t       head, skid, new_word;
    logic [31:0] cnt, word_addr;
    logic [31:0] pack_instr;
    logic        fmt_bad, range_bad;
    logic        accept, drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Field placement; mirrors the immediate decoder bit-for-bit.
    always_comb begin
        pack_instr = 32'h0;
        fmt_bad    = 1'b0;
        case (fmt)
            3'd0: pack_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: pack_instr = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2: pack_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd3: pack_instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
            3'd4: pack_instr = {imm[19:0], rd, opcode};
            3'd5: pack_instr = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
            default: begin
                pack_instr = 32'h0000_0013;  // NOP stands in for an illegal format
                fmt_bad    = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must be the sign extension of its 12- or 20-bit field.
    always_comb begin
        range_bad = 1'b0;
        case (fmt)
            3'd1, 3'd2, 3'd3: range_bad = (imm[31:11] != {21{imm[11]}});
            3'd4, 3'd5:       range_bad = (imm[31:19] != {13{imm[19]}});
            default:          range_bad = 1'b0;
        endcase
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = &{1'b0, imm[31:20]};
    assign range_bad     = 1'b0;
`endif

    // A restart coincident with an accept rebases that very word.
    assign word_addr = restart ? BASE_ADDR : cnt;
    assign new_word  = '{instr: pack_instr, addr: word_addr, err: fmt_bad | range_bad};

    // Address counter: +4 per accepted word, wrapping inside the window.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            cnt <= BASE_ADDR;
        else if (accept)
            cnt <= (word_addr == LAST_ADDR) ? BASE_ADDR : word_addr + 32'd4;
        else if (restart)
            cnt <= BASE_ADDR;
    end

    // Occupancy next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !drain)      state_nxt = TWO;
                else if (!accept && drain) state_nxt = EMPTY;
            end
            TWO:     if (drain) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Occupancy register; in_ready is registered from the next occupancy.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
        end
    end

    // Queue data: head feeds the output, skid catches a word while head stalls.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head <= RST_WORD;
            skid <= RST_WORD;
        end else begin
            case (state)
                EMPTY: if (accept) head <= new_word;
                ONE: begin
                    if (accept && drain) head <= new_word;
                    else if (accept)     skid <= new_word;
                end
                TWO:     if (drain) head <= skid;
                default: ;
            endcase
        end
    end

    assign out_valid = (state != EMPTY);
    assign out_instr = head.instr;
    assign out_addr  = head.addr;
    assign out_err   = head.err;

endmodule

// File: tb/tb_immediate_pack.sv
// Directed bench for immediate_pack (DEPTH_WORDS=4 so address wrap is reachable).
module tb_immediate_pack;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic EXP_RANGE = 1'b1;
`else
    localparam logic EXP_RANGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN, restart, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  fmt, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_instr, out_addr;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    immediate_pack #(.BASE_ADDR(32'h0), .DEPTH_WORDS(4)) dut (
        .clk(clk), .rstN(rstN), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // One word through an idle pipe with out_ready=1: visible one cycle later, then drained.
    task automatic send(input string tag, input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                        input logic [31:0] e_instr, input logic [31:0] e_addr, input logic e_err);
        drive(f, op, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        restart  = 1'b0;
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".instr"}, out_instr, e_instr);
        chk({tag, ".addr"},  out_addr,  e_addr);
        chk({tag, ".err"},   out_err,   e_err);
        cyc();
        chk({tag, ".drained"}, out_valid, 0);
    endtask

    initial begin
        rstN = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        repeat (2) cyc();
        chk("rst.in_ready",  in_ready,  1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.instr",     out_instr, 32'h0);
        chk("rst.addr",      out_addr,  32'h0);
        chk("rst.err",       out_err,   0);
        rstN = 1'b1;
        cyc();

        // Packing per format; unused fields carry junk that must be dropped.
        out_ready = 1'b1;
        send("i_imm5",  3'd1, 7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'd5,        32'h00500093, 32'd0,  1'b0);
        send("s_imm8",  3'd2, 7'h23, 5'd17, 5'd0, 5'd2, 3'd2, 7'h7F, 32'd8,        32'h00202423, 32'd4,  1'b0);
        send("sb_m2",   3'd3, 7'h63, 5'd9, 5'd0, 5'd0, 3'd0, 7'h55, 32'hFFFFFFFE,  32'hFE000EE3, 32'd8,  1'b0);
        send("uj_imm4", 3'd5, 7'h6F, 5'd0, 5'd7, 5'd9, 3'd5, 7'h55, 32'd4,         32'h0080006F, 32'd12, 1'b0);
        send("fmt7",    3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h01, 32'd1,         32'h00000013, 32'd0,  1'b1);
        send("i_2048",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h80000093, 32'd4,  EXP_RANGE);
        send("r_sub",   3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEADBEEF,  32'h403100B3, 32'd8,  1'b0);
        send("u_lui",   3'd4, 7'h37, 5'd5, 5'd6, 5'd7, 3'd3, 7'h11, 32'h00012345,  32'h123452B7, 32'd12, 1'b0);
        send("i_m1",    3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF,  32'hFFF00093, 32'd0,  1'b0);

        // Stand-alone restart rebases the counter (it sits at 4 here).
        restart = 1'b1;
        cyc();
        restart = 1'b0;

        // Backpressure: three back-to-back words, only two fit.
        out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        in_valid = 1'b1;
        cyc();
        chk("bp.ready1", in_ready,  1);
        chk("bp.valid1", out_valid, 1);
        chk("bp.instrA", out_instr, 32'h00100093);
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
        cyc();
        chk("bp.full", in_ready, 0);
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
        cyc();
        chk("bp.still_full", in_ready,  0);
        chk("bp.hold_instr", out_instr, 32'h00100093);
        chk("bp.hold_addr",  out_addr,  32'd0);
        out_ready = 1'b1;
        cyc();
        chk("bp.instrB", out_instr, 32'h00200093);
        chk("bp.addrB",  out_addr,  32'd4);
        chk("bp.ready2", in_ready,  1);
        cyc();
        in_valid = 1'b0;
        chk("bp.validC", out_valid, 1);
        chk("bp.instrC", out_instr, 32'h00300093);
        chk("bp.addrC",  out_addr,  32'd8);
        cyc();
        chk("bp.empty", out_valid, 0);

        // Restart coincident with accept: that word gets base, next gets base+4.
        restart = 1'b1;
        send("rs_a", 3'd4, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001, 32'h00001117, 32'd0, 1'b0);
        send("rs_b", 3'd4, 7'h17, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00002, 32'h00002197, 32'd4, 1'b0);

        // Reset with two words queued discards them.
        out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7);
        in_valid = 1'b1;
        repeat (2) cyc();
        in_valid = 1'b0;
        chk("mr.full", in_ready, 0);
        rstN = 1'b0;
        #1;
        chk("mr.valid", out_valid, 0);
        chk("mr.ready", in_ready,  1);
        chk("mr.instr", out_instr, 32'h0);
        chk("mr.addr",  out_addr,  32'h0);
        cyc();
        rstN = 1'b1;
        cyc();
        chk("mr.idle", out_valid, 0);
        out_ready = 1'b1;
        send("post_rst", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h00500093, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
